// File: rtl/mem_responder.sv
// Single-port word memory that answers each read/write request with a one-cycle
// mem_resp pulse a fixed LATENCY cycles after the request is accepted.
module mem_responder #(
    parameter int LATENCY   = 3,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        proto_err
);

    localparam int       DEPTH      = 1 << ADDR_BITS;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic [3:0] count;
    logic [3:0] count_next;
    logic       accept;
    logic       enter_resp;

    logic [ADDR_BITS-1:0] lat_index;
    logic [15:0]          lat_wdata;
    logic [1:0]           lat_be;
    logic                 lat_write;

    logic [ADDR_BITS-1:0] eff_index;
    logic [15:0]          eff_wdata;
    logic [1:0]           eff_be;
    logic                 eff_write;

    logic [15:0] mem_array [0:DEPTH-1];

    logic unused_addr_bits;
    assign unused_addr_bits = mem_address[0] ^ (|(mem_address >> (ADDR_BITS + 1)));

    // With LATENCY=1 the access happens on the acceptance edge itself, before the
    // latches hold anything, so the live inputs are used while still in IDLE.
    assign eff_index = (state == IDLE) ? mem_address[ADDR_BITS:1] : lat_index;
    assign eff_wdata = (state == IDLE) ? mem_wdata                : lat_wdata;
    assign eff_be    = (state == IDLE) ? mem_byte_enable          : lat_be;
    assign eff_write = (state == IDLE) ? mem_write                : lat_write;

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept     = 1'b1;
                    count_next = COUNT_LOAD;
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // A dropped request abandons the transaction before any access.
                if (!mem_read && !mem_write) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count <= 4'd1) begin
                    state_next = RESP;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    assign enter_resp = (state_next == RESP);
    assign mem_resp   = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            mem_rdata <= 16'h0000;
            proto_err <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept && mem_read && mem_write) begin
                proto_err <= 1'b1;
            end
            if (enter_resp && !eff_write) begin
                mem_rdata <= mem_array[eff_index];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_index <= mem_address[ADDR_BITS:1];
            lat_wdata <= mem_wdata;
            lat_be    <= mem_byte_enable;
            lat_write <= mem_write;
        end
    end

    // The array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && eff_write) begin
            if (eff_be[0]) begin
                mem_array[eff_index][7:0] <= eff_wdata[7:0];
            end
            if (eff_be[1]) begin
                mem_array[eff_index][15:8] <= eff_wdata[15:8];
            end
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 8: word-index width; array depth is 2^ADDR_BITS 16-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port mem_read, input, 1 bit: initiator read request, held until mem_resp.
REQ-006 SHALL have port mem_write, input, 1 bit: initiator write request, held until mem_resp.
REQ-007 SHALL have port mem_byte_enable, input, 2 bits: write byte mask; bit0 selects [7:0], bit1 selects [15:8].
REQ-008 SHALL have port mem_address, input, 16 bits: byte address.
REQ-009 SHALL have port mem_wdata, input, 16 bits: write data.
REQ-010 SHALL have port mem_resp, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port mem_rdata, output, 16 bits: registered read data.
REQ-012 SHALL have port proto_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-014 IDLE: when mem_read or mem_write is high at a clock edge, the block SHALL latch address, wdata, byte_enable and request type, load the countdown with LATENCY-1, and go to BUSY (or directly to RESP if LATENCY=1).
REQ-015 BUSY: the countdown SHALL decrement each cycle; when it reaches 0, the state SHALL go to RESP.
REQ-016 mem_resp SHALL be high exactly in the RESP cycle, i.e. LATENCY cycles after the acceptance edge, and low in every other cycle.
REQ-017 Word index SHALL be mem_address[ADDR_BITS:1]; bit 0 and bits above ADDR_BITS SHALL be ignored, so addresses alias modulo 2^(ADDR_BITS+1) bytes.
REQ-018 Read: mem_rdata SHALL be loaded from the array at the edge entering RESP, be valid during the RESP cycle, and hold that value until the next read response or reset.
REQ-019 Write: at the edge entering RESP, only the bytes whose byte_enable bit is 1 SHALL be updated from the latched wdata; mem_rdata SHALL be unchanged.
REQ-020 A write with byte_enable=00 SHALL complete with mem_resp and SHALL modify no array bytes.
REQ-021 Input changes after acceptance SHALL be ignored; the latched values SHALL be used.
REQ-022 Abort: if mem_read and mem_write are both low at an edge while in BUSY, the FSM SHALL return to IDLE with no array update and no mem_resp.
REQ-023 RESP SHALL always go to IDLE on the next edge; a request still high in the IDLE cycle SHALL be accepted as a new transaction, and back-to-back transactions SHALL have a minimum period of LATENCY+1 cycles.
REQ-024 If mem_read and mem_write are both high at acceptance, the transaction SHALL be treated as a write and proto_err SHALL be set.
REQ-025 proto_err SHALL remain set until reset.

Reset
REQ-026 While rst is high at an edge, the FSM SHALL go to IDLE, the countdown SHALL be cleared, and mem_resp, mem_rdata and proto_err SHALL be cleared to 0.
REQ-027 Reset SHALL take priority over all other events and SHALL abort any in-flight transaction with no array update and no mem_resp.
REQ-028 Array contents SHALL NOT be cleared by reset; contents are undefined at power-up and are retained across reset.

Verification
REQ-029 Write then read, LATENCY=3: write 0x1234 to addr 0x0040 with byte_enable 11 -> mem_resp high 3 cycles after acceptance; then read 0x0040 -> mem_rdata=0x1234 with mem_resp.
REQ-030 Byte mask: with 0x1234 at 0x0040, write 0xABCD with byte_enable 01 -> a read returns 0x12CD; then write 0xEF00 with byte_enable 10 -> a read returns 0xEFCD.
REQ-031 Aliasing, ADDR_BITS=8: write 0x5555 to 0x0201 -> a read of 0x0000 returns 0x5555.
REQ-032 Abort: drop mem_write after 1 BUSY cycle -> no mem_resp; a later read of that address returns the old value.
REQ-033 Reset mid-transaction: assert rst while in BUSY -> mem_resp, mem_rdata and proto_err are 0 and the FSM is in IDLE; the array is unchanged.
REQ-034 Protocol error: mem_read and mem_write both high with wdata 0x0F0F -> proto_err=1 stays 1, the write is performed, and mem_rdata is unchanged.
